usb_bulk_in_packetizer: RTL and testbench

Byte-stream packetizer that sits directly upstream of the USB bulk-IN AXI4-Stream sink (`s_axis_*`) of the ULPI bulk endpoint core. It frames an unbounded 8-bit sample stream into bulk packets by asserting `tlast` in three cases:

- after `MAX_PKT` bytes;
- on an upstream `tlast`;
- on an explicit flush, or an idle timeout that force-closes a partial packet.

The last accepted byte is held back one stage so that `tlast` can be attached to it retroactively.

---
 rtl/usb_bulk_in_packetizer.sv | 130 +++++++++++++
 tb/tb_usb_bulk_in_packetizer.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bulk_in_packetizer.sv
// usb_bulk_in_packetizer
// Frames an 8-bit byte stream into USB bulk-IN packets. Each accepted byte
// waits in a one-entry hold register. This lets tlast be attached to it after
// the fact when one of these closes the packet: a size limit, an upstream
// tlast, a flush request or an idle timeout.
//
// Handshake semantics (both AXI4-Stream ports): a byte transfers on a rising
// edge where valid and ready are both 1; once valid is raised, data and last
// stay stable until that transfer happens.
module usb_bulk_in_packetizer #(
    parameter int MAX_PKT = 512,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(MAX_PKT + 1)
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       flush_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic       s_axis_tlast_i,
    input  logic [7:0] s_axis_tdata_i,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tlast_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       pkt_done_o,
    output logic       timeout_o
);

    // Timer only needs to reach TIMEOUT-1; a zero TIMEOUT disables it.
    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                TMR_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // Hold register, byte counter and idle timer
    logic             hv;
    logic             hlast;
    logic [7:0]       hd;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;

    logic accept;
    logic out_free;
    logic move_nf;
    logic move_f;
    logic tmr_clr;
    logic tmr_fire;
    logic close_now;
    logic next_last;

    // Handshake and transfer decisions for the current cycle
    always_comb begin
        out_free        = !m_axis_tvalid_o || m_axis_tready_i;
        // A final hold blocks new input until it has drained to the output.
        s_axis_tready_o = !hv || (out_free && !hlast);
        accept          = s_axis_tvalid_i && s_axis_tready_o;
        // A non-final byte only leaves the hold when its successor arrives,
        // so a later close event can still mark it as last.
        move_nf         = hv && !hlast && accept;
        move_f          = hv && hlast && out_free;
        tmr_clr         = accept || !hv || hlast;
        tmr_fire        = TMR_EN && !tmr_clr && (tmr == TMR_LAST);
        // Flush or timeout retroactively closes a partial packet held here;
        // with nothing held, a flush is dropped (no zero-length packets).
        close_now       = hv && !hlast && !accept && (flush_i || tmr_fire);
        next_last       = s_axis_tlast_i || (cnt == CNT_LAST) || flush_i;
    end

    // Hold register and byte counter update
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hv    <= 1'b0;
            hlast <= 1'b0;
            hd    <= 8'h00;
            cnt   <= '0;
        end else if (accept) begin
            hv    <= 1'b1;
            hd    <= s_axis_tdata_i;
            hlast <= next_last;
            cnt   <= next_last ? '0 : cnt + CNT_W'(1);
        end else if (move_f) begin
            hv    <= 1'b0;
            hlast <= 1'b0;
        end else if (close_now) begin
            hlast <= 1'b1;
            cnt   <= '0;
        end
    end

    // Idle timer: counts cycles a partial packet sits in the hold unfed
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tmr       <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= tmr_fire;
            if (tmr_clr) begin
                tmr <= '0;
            end else if (TMR_EN) begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

    // Output register: loads from the hold, otherwise drains on ready
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tdata_o  <= 8'h00;
        end else if (move_nf || move_f) begin
            m_axis_tvalid_o <= 1'b1;
            m_axis_tlast_o  <= hlast;
            m_axis_tdata_o  <= hd;
        end else if (m_axis_tready_i) begin
            m_axis_tvalid_o <= 1'b0;
        end
    end

    // Packet-complete pulse, one cycle after the tlast handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_done_o <= 1'b0;
        end else begin
            pkt_done_o <= m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o;
        end
    end

endmodule

// File: tb/tb_usb_bulk_in_packetizer.sv
// Bench for usb_bulk_in_packetizer (MAX_PKT=512, TIMEOUT=16).
module tb_usb_bulk_in_packetizer;

  localparam int MAX_PKT = 512;
  localparam int TIMEOUT = 16;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       flush_i = 1'b0;
  logic       s_axis_tvalid_i = 1'b0;
  logic       s_axis_tready_o;
  logic       s_axis_tlast_i = 1'b0;
  logic [7:0] s_axis_tdata_i = 8'h00;
  logic       m_axis_tvalid_o;
  logic       m_axis_tready_i = 1'b1;
  logic       m_axis_tlast_o;
  logic [7:0] m_axis_tdata_o;
  logic       pkt_done_o;
  logic       timeout_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_to = 0;
  int to_cyc = -1;
  int last_stamp = -1;
  int acc_pre = 0;
  int zero_run = 0;
  bit rand_ready = 0;
  bit chk_stable = 0;
  bit prev_stall = 0;
  logic [8:0] prev_word = 9'h000;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  usb_bulk_in_packetizer #(.MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .flush_i         (flush_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tready_i (m_axis_tready_i),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .pkt_done_o      (pkt_done_o),
    .timeout_o       (timeout_o)
  );

  // ---------------- clock / reset block ----------------
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready: constant 1, or random with zero runs capped at 3 so
  // stalls never reach the idle timeout.
  always @(negedge aclk) begin
    if (rand_ready) begin
      if (zero_run >= 3) m_axis_tready_i = 1'b1;
      else m_axis_tready_i = 1'($urandom_range(0, 1));
      zero_run = m_axis_tready_i ? 0 : zero_run + 1;
    end else begin
      m_axis_tready_i = 1'b1;
      zero_run = 0;
    end
  end

  // Output monitor: samples 1 time unit before each rising edge.
  always @(negedge aclk) begin
    #4;
    if (aresetn) begin
      if (chk_stable && prev_stall) begin
        n_vec++;
        if (!m_axis_tvalid_o || {m_axis_tlast_o, m_axis_tdata_o} !== prev_word) begin
          n_bad++;
          $display("FAIL stall_stable @%0d: got valid=%0b word=%03h required valid=1 word=%03h",
                   cyc, m_axis_tvalid_o, {m_axis_tlast_o, m_axis_tdata_o}, prev_word);
        end
      end
      prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
      prev_word  = {m_axis_tlast_o, m_axis_tdata_o};
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        got_q.push_back({m_axis_tlast_o, m_axis_tdata_o});
        if (m_axis_tlast_o) last_stamp = cyc;
      end
      if (pkt_done_o) n_done++;
      if (timeout_o) begin
        n_to++;
        to_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one byte and waits (bounded) until it is accepted.
  task automatic push(input logic [7:0] d, input logic l, input logic f);
    int guard;
    bit done;
    s_axis_tvalid_i = 1'b1;
    s_axis_tdata_i  = d;
    s_axis_tlast_i  = l;
    flush_i         = f;
    guard = 0;
    done  = 0;
    while (!done) begin
      #1;
      done    = s_axis_tready_o;
      acc_pre = cyc;
      @(posedge aclk);
      @(negedge aclk);
      guard++;
      if (!done && guard > 200) begin
        $display("FAIL push_timeout: got tready=0 for %0d cycles required acceptance", guard);
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "upstream stalled");
      end
    end
  endtask

  task automatic idle();
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
    flush_i         = 1'b0;
  endtask

  // Waits (bounded) for n output bytes, then a quiet margin to catch extras.
  task automatic wait_drain(input int n);
    int g;
    g = 0;
    while (got_q.size() < n && g < 600) begin
      @(negedge aclk);
      g++;
    end
    repeat (24) @(negedge aclk);
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    idle();
    repeat (3) @(negedge aclk);
    #1;
    n_vec++;
    if ({m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, pkt_done_o, timeout_o} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %03h required 000",
               {m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, pkt_done_o, timeout_o});
    end
    n_vec++;
    if (s_axis_tready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tready: got %0b required 1", s_axis_tready_o);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_max_split();
    int d0, t0;
    clear_sb();
    d0 = n_done;
    t0 = n_to;
    for (int i = 0; i < 1024; i++) begin
      push(8'(i), 1'b0, 1'b0);
      exp_q.push_back({(i == 511 || i == 1023), 8'(i)});
    end
    idle();
    wait_drain(exp_q.size());
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL max_split_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL max_split_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
    n_vec++;
    if (n_done - d0 != 2) begin
      n_bad++;
      $display("FAIL max_split_pkt_done: got %0d pulses required 2", n_done - d0);
    end
    n_vec++;
    if (n_to - t0 != 0) begin
      n_bad++;
      $display("FAIL max_split_timeout: got %0d pulses required 0", n_to - t0);
    end
  endtask

  task automatic test_timeout();
    int t0, a3;
    clear_sb();
    t0 = n_to;
    push(8'hA1, 1'b0, 1'b0);
    push(8'hA2, 1'b0, 1'b0);
    push(8'hA3, 1'b0, 1'b0);
    a3 = acc_pre + 1;
    idle();
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b1, 8'hA3});
    wait_drain(3);
    n_vec++;
    if (got_q.size() != 3) begin
      n_bad++;
      $display("FAIL timeout_count: got %0d bytes required 3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL timeout_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (n_to - t0 != 1) begin
      n_bad++;
      $display("FAIL timeout_pulses: got %0d required 1", n_to - t0);
    end
    n_vec++;
    if (to_cyc != a3 + TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_pulse_edge: got %0d required %0d", to_cyc, a3 + TIMEOUT);
    end
    n_vec++;
    if (last_stamp != a3 + TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL timeout_tlast_edge: got %0d required %0d", last_stamp, a3 + TIMEOUT + 1);
    end
    // Counter must restart from zero: next 512 bytes form one full packet.
    clear_sb();
    for (int i = 0; i < 512; i++) begin
      push(8'(i * 3), 1'b0, 1'b0);
      exp_q.push_back({(i == 511), 8'(i * 3)});
    end
    idle();
    wait_drain(512);
    n_vec++;
    if (got_q.size() != 512) begin
      n_bad++;
      $display("FAIL timeout_after_count: got %0d bytes required 512", got_q.size());
    end
    for (int i = 0; i < 512 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL timeout_after_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_upstream_tlast();
    int c, d0, t0;
    logic l;
    logic [8:0] t;
    clear_sb();
    d0 = n_done;
    t0 = n_to;
    c = 0;
    for (int i = 0; i < 610; i++) begin
      l = (i == 9) || (c == MAX_PKT - 1);
      c = l ? 0 : c + 1;
      push(8'(i * 7), (i == 9), 1'b0);
      exp_q.push_back({l, 8'(i * 7)});
    end
    idle();
    t = exp_q.pop_back();
    t[8] = 1'b1;
    exp_q.push_back(t);
    wait_drain(exp_q.size());
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL upstream_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL upstream_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
    n_vec++;
    if (n_done - d0 != 3 || n_to - t0 != 1) begin
      n_bad++;
      $display("FAIL upstream_pulses: got done=%0d timeout=%0d required done=3 timeout=1",
               n_done - d0, n_to - t0);
    end
  endtask

  task automatic test_flush();
    int d0, t0;
    clear_sb();
    d0 = n_done;
    t0 = n_to;
    // Flush with nothing held must produce nothing.
    flush_i = 1'b1;
    @(negedge aclk);
    flush_i = 1'b0;
    repeat (30) @(negedge aclk);
    n_vec++;
    if (got_q.size() != 0 || n_done != d0) begin
      n_bad++;
      $display("FAIL flush_empty: got %0d bytes %0d done required 0 0", got_q.size(), n_done - d0);
    end
    // Flush together with byte 5, then a full 512-byte packet.
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h50 + i), 1'b0, (i == 4));
      exp_q.push_back({(i == 4), 8'(8'h50 + i)});
    end
    for (int i = 0; i < 512; i++) begin
      push(8'(i + 1), 1'b0, 1'b0);
      exp_q.push_back({(i == 511), 8'(i + 1)});
    end
    // Flush on an idle cycle closes a held partial packet of 3.
    for (int i = 0; i < 3; i++) begin
      push(8'(8'hC0 + i), 1'b0, 1'b0);
      exp_q.push_back({(i == 2), 8'(8'hC0 + i)});
    end
    idle();
    @(negedge aclk);
    flush_i = 1'b1;
    @(negedge aclk);
    flush_i = 1'b0;
    wait_drain(exp_q.size());
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL flush_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL flush_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
    n_vec++;
    if (n_done - d0 != 3 || n_to - t0 != 0) begin
      n_bad++;
      $display("FAIL flush_pulses: got done=%0d timeout=%0d required done=3 timeout=0",
               n_done - d0, n_to - t0);
    end
  endtask

  task automatic test_backpressure();
    int c, d0;
    logic l, ul;
    logic [7:0] d;
    logic [8:0] t;
    clear_sb();
    d0 = n_done;
    rand_ready = 1;
    chk_stable = 1;
    c = 0;
    for (int i = 0; i < 2000; i++) begin
      d  = 8'($urandom_range(0, 255));
      ul = ((i % 700) == 699);
      l  = ul || (c == MAX_PKT - 1);
      c  = l ? 0 : c + 1;
      push(d, ul, 1'b0);
      exp_q.push_back({l, d});
    end
    idle();
    t = exp_q.pop_back();
    t[8] = 1'b1;
    exp_q.push_back(t);
    wait_drain(exp_q.size());
    rand_ready = 0;
    chk_stable = 0;
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bp_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
    n_vec++;
    if (n_done - d0 != 6) begin
      n_bad++;
      $display("FAIL bp_pkt_done: got %0d pulses required 6", n_done - d0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200; i++) push(8'(i), 1'b0, 1'b0);
    s_axis_tvalid_i = 1'b0;
    #1;
    n_vec++;
    if (m_axis_tvalid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pre_valid: got %0b required 1", m_axis_tvalid_o);
    end
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    #1;
    n_vec++;
    if ({m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, pkt_done_o, timeout_o} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %03h required 000",
               {m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, pkt_done_o, timeout_o});
    end
    n_vec++;
    if (s_axis_tready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_tready: got %0b required 1", s_axis_tready_o);
    end
    aresetn = 1'b1;
    clear_sb();
    @(negedge aclk);
    for (int i = 0; i < 512; i++) begin
      push(8'(255 - i), 1'b0, 1'b0);
      exp_q.push_back({(i == 511), 8'(255 - i)});
    end
    idle();
    wait_drain(512);
    n_vec++;
    if (got_q.size() != 512) begin
      n_bad++;
      $display("FAIL reset_mid_count: got %0d bytes required 512", got_q.size());
    end
    for (int i = 0; i < 512 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL reset_mid_byte[%0d]: got %03h required %03h", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    @(negedge aclk);
    test_reset();
    test_max_split();
    test_timeout();
    test_upstream_tlast();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
